serial_subtractor: RTL and testbench

Bit-serial, LSB-first unsigned subtractor computing `a - b` for WIDTH-bit operands. Each cycle it does one bit-slice of the subtraction: two cascaded half-subtractor stages plus a registered borrow flip-flop. It sits directly upstream of result consumers and replaces a WIDTH-wide ripple subtractor where area matters more than latency. A start/busy/done handshake frames each operation.

---
 rtl/serial_subtractor.sv | 126 ++++++++++++
 tb/tb_serial_subtractor.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first unsigned subtractor with start/busy/done framing
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             bw_q, bw_d;
   logic             borrow_q, borrow_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   // one bit slice: two cascaded half subtractors
   logic hs1_diff, hs1_borrow;
   logic hs2_diff, hs2_borrow;
   logic slice_borrow;

   // bit-slice datapath on the current LSBs and the stored borrow
   always_comb begin
      hs1_diff     = sa_q[0] ^ sb_q[0];
      hs1_borrow   = ~sa_q[0] & sb_q[0];
      hs2_diff     = hs1_diff ^ bw_q;
      hs2_borrow   = ~hs1_diff & bw_q;
      slice_borrow = hs1_borrow | hs2_borrow;
   end

   // next-state, shift registers and registered outputs
   always_comb begin
      state_d  = state_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      sr_d     = sr_q;
      cnt_d    = cnt_q;
      bw_d     = bw_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               sa_d    = a;
               sb_d    = b;
               bw_d    = 1'b0;
               cnt_d   = '0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            sa_d  = sa_q >> 1;
            sb_d  = sb_q >> 1;
            sr_d  = {hs2_diff, sr_q[WIDTH-1:1]};
            bw_d  = slice_borrow;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               // result is taken from the same shifted value so it lands with DONE
               diff_d   = {hs2_diff, sr_q[WIDTH-1:1]};
               borrow_d = slice_borrow;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   // state register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         sa_q     <= '0;
         sb_q     <= '0;
         sr_q     <= '0;
         cnt_q    <= '0;
         bw_q     <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         sr_q     <= sr_d;
         cnt_q    <= cnt_d;
         bw_q     <= bw_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign diff   = diff_q;
   assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed and random checks of serial_subtractor at WIDTH 8 and 2
module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start8, start2;
   logic [7:0] a8, b8;
   logic [1:0] a2, b2;
   logic       busy8, done8, borrow8;
   logic       busy2, done2, borrow2;
   logic [7:0] diff8;
   logic [1:0] diff2;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] prev8;
   logic       prevb8;
   logic [1:0] prev2;
   logic       prevb2;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
   );

   serial_subtractor #(.WIDTH(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
      .busy(busy2), .done(done2), .diff(diff2), .borrow(borrow2)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // one full operation on the selected instance, starting in IDLE; ends in cycle w+2
   task automatic run_op(input int w, input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] ed, input logic eb, input string tag);
      logic       o_busy, o_done, o_borrow;
      logic [7:0] o_diff, p_diff;
      logic       p_b;
      if (w == 8) begin
         a8 = av; b8 = bv; start8 = 1'b1;
         p_diff = prev8; p_b = prevb8;
      end else begin
         a2 = av[1:0]; b2 = bv[1:0]; start2 = 1'b1;
         p_diff = {6'd0, prev2}; p_b = prevb2;
      end
      for (int c = 1; c <= w + 2; c++) begin
         step();
         start8 = 1'b0;
         start2 = 1'b0;
         o_busy   = (w == 8) ? busy8 : busy2;
         o_done   = (w == 8) ? done8 : done2;
         o_borrow = (w == 8) ? borrow8 : borrow2;
         o_diff   = (w == 8) ? diff8 : {6'd0, diff2};
         if (c <= w) begin
            chk({tag, " busy_shift"}, o_busy, 1'b1);
            chk({tag, " done_shift"}, o_done, 1'b0);
            chk({tag, " diff_hold"}, o_diff, p_diff);
            chk({tag, " borrow_hold"}, o_borrow, p_b);
         end else if (c == w + 1) begin
            chk({tag, " busy_done"}, o_busy, 1'b1);
            chk({tag, " done"}, o_done, 1'b1);
            chk({tag, " diff"}, o_diff, ed);
            chk({tag, " borrow"}, o_borrow, eb);
         end else begin
            chk({tag, " busy_idle"}, o_busy, 1'b0);
            chk({tag, " done_idle"}, o_done, 1'b0);
            chk({tag, " diff_after"}, o_diff, ed);
         end
      end
      if (w == 8) begin
         prev8 = ed; prevb8 = eb;
      end else begin
         prev2 = ed[1:0]; prevb2 = eb;
      end
   endtask

   initial begin
      logic [7:0] ra, rb;
      rst_n = 1'b0;
      start8 = 1'b1; start2 = 1'b1;
      a8 = 8'h55; b8 = 8'hAA; a2 = 2'd1; b2 = 2'd2;
      prev8 = 8'h00; prevb8 = 1'b0; prev2 = 2'd0; prevb2 = 1'b0;

      // reset with start held high must not start anything
      step();
      step();
      chk("rst busy8", busy8, 1'b0);
      chk("rst done8", done8, 1'b0);
      chk("rst diff8", diff8, 8'h00);
      chk("rst borrow8", borrow8, 1'b0);
      chk("rst busy2", busy2, 1'b0);
      chk("rst diff2", diff2, 2'd0);
      start8 = 1'b0; start2 = 1'b0;
      rst_n = 1'b1;
      step();
      chk("post_rst busy8", busy8, 1'b0);
      chk("post_rst busy2", busy2, 1'b0);

      // directed vectors
      run_op(8, 8'd10,  8'd3,   8'h07, 1'b0, "10-3");
      run_op(8, 8'd3,   8'd10,  8'hF9, 1'b1, "3-10");
      run_op(8, 8'h00,  8'h01,  8'hFF, 1'b1, "0-1");
      run_op(8, 8'hFF,  8'hFF,  8'h00, 1'b0, "FF-FF");
      run_op(8, 8'h00,  8'h00,  8'h00, 1'b0, "0-0");
      run_op(8, 8'h80,  8'h7F,  8'h01, 1'b0, "80-7F");
      run_op(2, 8'd1,   8'd2,   8'd3,  1'b1, "w2 1-2");
      run_op(2, 8'd3,   8'd1,   8'd2,  1'b0, "w2 3-1");

      // start while busy: second request in SHIFT and in DONE is dropped
      a8 = 8'd5; b8 = 8'd2; start8 = 1'b1;
      for (int c = 1; c <= 11; c++) begin
         step();
         start8 = 1'b0;
         if (c <= 8) begin
            chk("sb done_low", done8, 1'b0);
            chk("sb busy_high", busy8, 1'b1);
         end
         if (c == 4) begin
            a8 = 8'd9; b8 = 8'd1; start8 = 1'b1;
         end
         if (c == 9) begin
            chk("sb done", done8, 1'b1);
            chk("sb diff", diff8, 8'h03);
            chk("sb borrow", borrow8, 1'b0);
            a8 = 8'd9; b8 = 8'd1; start8 = 1'b1;
         end
         if (c >= 10) begin
            chk("sb busy_after", busy8, 1'b0);
            chk("sb done_after", done8, 1'b0);
            chk("sb diff_after", diff8, 8'h03);
         end
      end

      // reset in the middle of an operation
      a8 = 8'h20; b8 = 8'h01; start8 = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         step();
         start8 = 1'b0;
         rst_n = 1'b1;
         if (c <= 5) chk("mr busy", busy8, 1'b1);
         if (c == 5) rst_n = 1'b0;
         if (c >= 6) begin
            chk("mr busy_cleared", busy8, 1'b0);
            chk("mr done_none", done8, 1'b0);
            chk("mr diff_cleared", diff8, 8'h00);
            chk("mr borrow_cleared", borrow8, 1'b0);
         end
      end
      prev8 = 8'h00; prevb8 = 1'b0;
      prev2 = 2'd0;  prevb2 = 1'b0;
      run_op(8, 8'h20, 8'h01, 8'h1F, 1'b0, "20-01");

      // continuous start: accepts every WIDTH+2 cycles
      a8 = 8'd200; b8 = 8'd55; start8 = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         step();
         chk("cont done", done8, (c == 9 || c == 19 || c == 29) ? 1'b1 : 1'b0);
         chk("cont busy", busy8, (c % 10 != 0) ? 1'b1 : 1'b0);
         chk("cont diff", diff8, (c < 9) ? 8'h1F : 8'd145);
      end
      start8 = 1'b0;
      step();
      chk("cont stop busy", busy8, 1'b0);
      prev8 = 8'd145; prevb8 = 1'b0;

      // random sweeps against (a-b) mod 2^w and a<b
      for (int i = 0; i < 12; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         run_op(8, ra, rb, ra - rb, (ra < rb), "rand8");
      end
      for (int i = 0; i < 10; i++) begin
         ra = 8'($urandom_range(0, 3));
         rb = 8'($urandom_range(0, 3));
         run_op(2, ra, rb, (ra - rb) & 8'h03, (ra < rb), "rand2");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
